// File: rtl/regfile_read_stage_if.sv
// Handshake bundle between the operand-fetch stage, its producer and execute.
// master drives instructions in and consumes results; slave is the stage.
interface regfile_read_stage_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_instr;
   logic [WIDTH-1:0] out_opa;
   logic [WIDTH-1:0] out_opb;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_opa, out_opb
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_opa, out_opb
   );
endinterface

// File: rtl/regfile_read_stage.sv
// Operand fetch with RAW scoreboard over an 8x16 register file.
// Optional REGREAD_BYPASS_EN forwards the write-back bus into hazard and operands.
module regfile_read_stage #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             flush,
   input  logic [WIDTH-1:0] q0,
   input  logic [WIDTH-1:0] q1,
   input  logic [WIDTH-1:0] q2,
   input  logic [WIDTH-1:0] q3,
   input  logic [WIDTH-1:0] q4,
   input  logic [WIDTH-1:0] q5,
   input  logic [WIDTH-1:0] q6,
   input  logic [WIDTH-1:0] q7,
   input  logic             wb_load,
   input  logic [15:0]      wb_wsel,
   input  logic [WIDTH-1:0] wb_d_a,
   input  logic [WIDTH-1:0] wb_d_d,
   regfile_read_stage_if.slave bus
);

   function automatic logic writes(input logic [15:0] w);
      return !w[15] && !(w[15:14] == 2'b00 && w[4:0] == 5'd0);
   endfunction

   function automatic logic is_ld(input logic [15:0] w);
      return w[15:14] == 2'b00 && w[4:0] == 5'd1;
   endfunction

   logic [WIDTH-1:0] rf [8];
   logic             wb_wr;
   logic [2:0]       wb_dst;
   logic [WIDTH-1:0] wb_dat;
   logic [2:0]       ra, rb, od;
   logic [7:0]       busy, busy_eff, busy_nxt;
   logic             out_wr, hazard;
   logic             fire_in, fire_out;
   logic [WIDTH-1:0] opa_n, opb_n;

   logic             ov_q;
   logic [15:0]      oi_q;
   logic [WIDTH-1:0] oa_q, ob_q;

   assign rf[0] = q0;
   assign rf[1] = q1;
   assign rf[2] = q2;
   assign rf[3] = q3;
   assign rf[4] = q4;
   assign rf[5] = q5;
   assign rf[6] = q6;
   assign rf[7] = q7;

   assign wb_wr  = wb_load && writes(wb_wsel);
   assign wb_dst = wb_wsel[13:11];
   assign wb_dat = is_ld(wb_wsel) ? wb_d_d : wb_d_a;

   assign ra = bus.in_instr[13:11];
   assign rb = bus.in_instr[10:8];
   assign od = oi_q[13:11];

   assign out_wr = ov_q && writes(oi_q);

   // The instruction sitting in the output register is a producer too.
   always_comb begin
      busy_eff = busy;
`ifdef REGREAD_BYPASS_EN
      if (wb_wr)
         busy_eff[wb_dst] = 1'b0;
`endif
      if (out_wr)
         busy_eff[od] = 1'b1;
   end

   assign hazard = bus.in_valid && (busy_eff[ra] || busy_eff[rb]);

   assign bus.in_ready = (!ov_q || bus.out_ready) && !hazard && !flush;

   assign fire_in  = bus.in_valid && bus.in_ready;
   assign fire_out = ov_q && bus.out_ready;

   always_comb begin
      opa_n = rf[ra];
      opb_n = rf[rb];
`ifdef REGREAD_BYPASS_EN
      if (wb_wr && wb_dst == ra)
         opa_n = wb_dat;
      if (wb_wr && wb_dst == rb)
         opb_n = wb_dat;
`endif
   end

`ifndef REGREAD_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^wb_dat;
`endif
   logic unused_sel;
   assign unused_sel = ^wb_wsel[10:5];

   // Set after clear: a newer producer outranks an older write-back.
   always_comb begin
      busy_nxt = busy;
      if (wb_wr)
         busy_nxt[wb_dst] = 1'b0;
      if (fire_out && !flush && writes(oi_q))
         busy_nxt[od] = 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         busy <= 8'h00;
         ov_q <= 1'b0;
         oi_q <= 16'h0000;
         oa_q <= '0;
         ob_q <= '0;
      end else begin
         busy <= busy_nxt;
         if (fire_in) begin
            ov_q <= 1'b1;
            oi_q <= bus.in_instr;
            oa_q <= opa_n;
            ob_q <= opb_n;
         end else if (fire_out || flush) begin
            ov_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.out_instr = oi_q;
   assign bus.out_opa   = oa_q;
   assign bus.out_opb   = ob_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Randomized scoreboard bench for regfile_read_stage with a downstream
// model that retires writers back onto the write-back bus.
module tb_regfile_read_stage;

`ifdef REGREAD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [15:0] instr;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b1;
   logic        flush = 1'b0;
   logic        wb_load = 1'b0;
   logic [15:0] wb_wsel = '0;
   logic [15:0] wb_d_a = '0;
   logic [15:0] wb_d_d = '0;
   logic [15:0] qv [8];

   logic [15:0] R [8];
   logic [7:0]  pend;
   exp_t        sb [$];
   logic [15:0] ds [$];

   int checks = 0;
   int failures = 0;
   bit mon_en = 0;

   regfile_read_stage_if #(.WIDTH(16)) bus ();

   regfile_read_stage #(.WIDTH(16)) dut (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .flush   (flush),
      .q0      (qv[0]),
      .q1      (qv[1]),
      .q2      (qv[2]),
      .q3      (qv[3]),
      .q4      (qv[4]),
      .q5      (qv[5]),
      .q6      (qv[6]),
      .q7      (qv[7]),
      .wb_load (wb_load),
      .wb_wsel (wb_wsel),
      .wb_d_a  (wb_d_a),
      .wb_d_d  (wb_d_d),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic writes(input logic [15:0] w);
      return !w[15] && !(w[15:14] == 2'b00 && w[4:0] == 5'd0);
   endfunction

   function automatic logic is_ld(input logic [15:0] w);
      return w[15:14] == 2'b00 && w[4:0] == 5'd1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the stage hands off a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (mon_en && RSTN) begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out actual=%0h expected=none",
                           bus.out_instr);
               end else begin
                  e = sb.pop_front();
                  chk("out_instr", {16'd0, bus.out_instr}, {16'd0, e.instr});
                  chk("out_opa", {16'd0, bus.out_opa}, {16'd0, e.a});
                  chk("out_opb", {16'd0, bus.out_opb}, {16'd0, e.b});
               end
            end
         end
      end
   end

   task automatic step(input logic iv, input logic [15:0] ii,
                       input logic ordy, input logic fl,
                       input logic wl, input logic [15:0] ww,
                       input logic [15:0] da, input logic [15:0] dd,
                       output logic acc);
      logic        wbw, exp_rdy, fo, od;
      logic [2:0]  wbd;
      logic [15:0] wbv;
      logic [7:0]  pe;
      exp_t        h, n;
      od = ordy && !fl;
      @(negedge CLK);
      for (int i = 0; i < 8; i++)
         qv[i] = R[i];
      bus.in_valid  = iv;
      bus.in_instr  = ii;
      bus.out_ready = od;
      flush   = fl;
      wb_load = wl;
      wb_wsel = ww;
      wb_d_a  = da;
      wb_d_d  = dd;
      wbw = wl && writes(ww);
      wbd = ww[13:11];
      wbv = is_ld(ww) ? dd : da;
      pe = pend;
      if (BYP && wbw)
         pe[wbd] = 1'b0;
      if (sb.size() > 0 && writes(sb[0].instr))
         pe[sb[0].instr[13:11]] = 1'b1;
      exp_rdy = (sb.size() == 0 || od) && !fl &&
                !(iv && (pe[ii[13:11]] || pe[ii[10:8]]));
      fo = sb.size() > 0 && od;
      if (fo)
         h = sb[0];
      n.instr = ii;
      n.a = (BYP && wbw && wbd == ii[13:11]) ? wbv : R[ii[13:11]];
      n.b = (BYP && wbw && wbd == ii[10:8]) ? wbv : R[ii[10:8]];
      #2;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      acc = iv && exp_rdy;
      if (fl && sb.size() > 0)
         sb.delete(0);
      if (acc)
         sb.push_back(n);
      if (wbw)
         pend[wbd] = 1'b0;
      if (fo && writes(h.instr)) begin
         pend[h.instr[13:11]] = 1'b1;
         ds.push_back(h.instr);
      end
      if (wbw)
         R[wbd] = wbv;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTN = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      flush   = 1'b0;
      wb_load = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_instr", {16'd0, bus.out_instr}, 32'd0);
      chk("rst_out_opa", {16'd0, bus.out_opa}, 32'd0);
      chk("rst_out_opb", {16'd0, bus.out_opb}, 32'd0);
      sb.delete();
      ds.delete();
      pend = 8'h00;
      repeat (2) @(negedge CLK);
      RSTN = 1'b1;
   endtask

   initial begin
      logic        a, iv, ordy, fl, wl;
      logic [15:0] ii, ww;
      for (int i = 0; i < 8; i++) begin
         R[i]  = 16'($urandom);
         qv[i] = R[i];
      end
      pend = 8'h00;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.out_ready = 1'b0;
      do_reset();
      mon_en = 1;

      // Independent writers go back to back.
      step(1, 16'h4800, 1, 0, 0, 0, 0, 0, a);
      step(1, 16'h5C00, 1, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);

      // LD r5 then a reader of r5 stalls until write-back.
      step(1, 16'h2801, 1, 0, 0, 0, 0, 0, a);
      for (int k = 0; k < 10; k++) begin
         step(1, 16'h6E02, 1, 0, k == 3, 16'h2801, 16'h1234, 16'hBEEF, a);
         if (a)
            break;
      end

      // Output held while downstream is not ready.
      for (int k = 0; k < 3; k++)
         step(1, 16'h4000, 0, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);

      // Flushed writer must not mark r2 busy.
      step(1, 16'h5000, 0, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 0, 1, 0, 0, 0, 0, a);
      step(1, 16'h5100, 1, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);

      // Non-writers never stall a reader of their [13:11].
      step(1, 16'h3000, 1, 0, 0, 0, 0, 0, a);
      step(1, 16'hB000, 1, 0, 0, 0, 0, 0, a);
      step(1, 16'hF000, 1, 0, 0, 0, 0, 0, a);
      step(1, 16'h7700, 1, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);

      do_reset();

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500)
            do_reset();
         iv = ($urandom % 4) != 0;
         ii = 16'($urandom);
         if ($urandom % 2 == 1) begin
            ii[13:11] = 3'($urandom_range(0, 3));
            ii[10:8]  = 3'($urandom_range(0, 3));
         end
         ordy = ($urandom % 4) != 0;
         fl   = ($urandom % 20) == 0;
         wl   = 1'b0;
         ww   = 16'($urandom);
         if (ds.size() > 0 && $urandom % 3 == 0) begin
            wl = 1'b1;
            ww = ds.pop_front();
         end else if ($urandom % 25 == 0) begin
            wl = 1'b1;
         end
         step(iv, ii, ordy, fl, wl, ww, 16'($urandom), 16'($urandom), a);
      end

      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);
      step(0, 16'h0000, 1, 0, 0, 0, 0, 0, a);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
